// File: rtl/hazard_ctrl.sv
// Purpose : Pipeline hazard controller. It handles load-use, ALU->branch and load->branch
//           stalls, memory-wait freezes, and the taken-branch flush of IF/ID.
// Latency : Decisions are combinational in the same cycle. Only the FSM state and stall_cnt are registered.
// Backpr. : While dmem_ready is low the whole pipeline is frozen (exmem_hold). Stalls insert ID/EX bubbles.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   id_rs, id_rt, id_uses_rt       source registers of the instruction in IF/ID
//   id_branch, branch_taken        branch resolved in ID and its comparator result
//   ex_regwrite, ex_memread, ex_rd writer/load info for the instruction in EX
//   mem_memread, mem_access, mem_rd load/store info for the instruction in MEM
//   dmem_ready                     data memory completes its access this cycle
//   pc_write, ifid_write           PC and IF/ID load enables
//   ifid_flush                     zero IF/ID on the next edge
//   idex_bubble                    select zero control lines into ID/EX
//   exmem_hold                     hold EX/MEM and ID/EX during a memory wait
//   stall_cnt                      remaining stall cycles (debug)
module hazard_ctrl #(
    parameter int REG_W             = 5,
    parameter int LOAD_USE_STALL    = 1,
    parameter int LOAD_BRANCH_STALL = 2,
    parameter int ALU_BRANCH_STALL  = 1,
    parameter int CNT_W             = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             branch_taken,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_memread,
    input  logic             mem_access,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] N_LOAD_USE    = CNT_W'(LOAD_USE_STALL);
    localparam logic [CNT_W-1:0] N_LOAD_BRANCH = CNT_W'(LOAD_BRANCH_STALL);
    localparam logic [CNT_W-1:0] N_ALU_BRANCH  = CNT_W'(ALU_BRANCH_STALL);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STALL    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A register matches when it is non-zero and equals the ID instruction's rs,
    // or its rt when that instruction actually reads rt.
    logic ex_match, mem_match;
    assign ex_match  = (ex_rd  != '0) && ((ex_rd  == id_rs) || (id_uses_rt && (ex_rd  == id_rt)));
    assign mem_match = (mem_rd != '0) && ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));

    logic mem_wait_req;
    assign mem_wait_req = mem_access && !dmem_ready;

    // Stall hazards in priority order. The first hit selects the stall length.
    logic             hz_hit;
    logic [CNT_W-1:0] hz_len;
    always_comb begin
        hz_hit = 1'b0;
        hz_len = '0;
        if (id_branch && ex_memread && ex_match) begin
            hz_hit = 1'b1;
            hz_len = N_LOAD_BRANCH;
        end else if (id_branch && ex_regwrite && !ex_memread && ex_match) begin
            hz_hit = 1'b1;
            hz_len = N_ALU_BRANCH;
        end else if (id_branch && mem_memread && mem_match) begin
            hz_hit = 1'b1;
            hz_len = CNT_ONE;
        end else if (!id_branch && ex_memread && ex_match) begin
            hz_hit = 1'b1;
            hz_len = N_LOAD_USE;
        end
    end

    // Cycle classification. Exactly one of do_wait / do_stall / normal applies.
    logic do_wait, do_stall, do_flush;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        do_wait  = 1'b0;
        do_stall = 1'b0;
        do_flush = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_wait_req) begin
                    do_wait = 1'b1;
                    state_d = MEM_WAIT;
                end else if (hz_hit) begin
                    // This cycle is already stall cycle 1.
                    do_stall = 1'b1;
                    if (hz_len > CNT_ONE) begin
                        cnt_d   = hz_len - CNT_ONE;
                        state_d = STALL;
                    end
                end else begin
                    do_flush = id_branch && branch_taken;
                end
            end

            STALL: begin
                if (mem_wait_req) begin
                    // Freeze the remaining count and resume the stall afterwards.
                    do_wait = 1'b1;
                    state_d = MEM_WAIT;
                end else begin
                    do_stall = 1'b1;
                    cnt_d    = cnt_q - CNT_ONE;
                    state_d  = (cnt_q == CNT_ONE) ? IDLE : STALL;
                end
            end

            MEM_WAIT: begin
                if (mem_wait_req) begin
                    do_wait = 1'b1;
                end else if (cnt_q != '0) begin
                    // The ready cycle behaves as the resumed stall cycle.
                    do_stall = 1'b1;
                    cnt_d    = cnt_q - CNT_ONE;
                    state_d  = (cnt_q == CNT_ONE) ? IDLE : STALL;
                end else begin
                    // The ready cycle is a full IDLE evaluation.
                    state_d = IDLE;
                    if (hz_hit) begin
                        do_stall = 1'b1;
                        if (hz_len > CNT_ONE) begin
                            cnt_d   = hz_len - CNT_ONE;
                            state_d = STALL;
                        end
                    end else begin
                        do_flush = id_branch && branch_taken;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset forces every control output low for as long as rst is held.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_hold  = 1'b0;
        if (!rst) begin
            pc_write    = !(do_wait || do_stall);
            ifid_write  = !(do_wait || do_stall);
            ifid_flush  = do_flush;
            idex_bubble = do_stall;
            exmem_hold  = do_wait;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_uses_rt, id_branch, branch_taken;
    logic       ex_regwrite, ex_memread, mem_memread, mem_access, dmem_ready;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold;
    logic [2:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}
    localparam logic [4:0] O_NORM  = 5'b11000;
    localparam logic [4:0] O_FLUSH = 5'b11100;
    localparam logic [4:0] O_STALL = 5'b00010;
    localparam logic [4:0] O_WAIT  = 5'b00001;
    localparam logic [4:0] O_RST   = 5'b00000;

    logic [4:0] obs;
    assign obs = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold};

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .branch_taken(branch_taken),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_memread(mem_memread), .mem_access(mem_access), .mem_rd(mem_rd),
        .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_hold(exmem_hold), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        id_branch = 1'b0; branch_taken = 1'b0;
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
        mem_memread = 1'b0; mem_access = 1'b0; mem_rd = 5'd0;
        dmem_ready = 1'b1;
    endtask

    task automatic clear_ex();
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        id_rs = 5'd3;
        tick(); tick();
        total++; if (obs !== O_RST) begin bad++; $display("FAIL reset_out got=%b want=%b", obs, O_RST); end
        total++; if (stall_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt); end
        rst = 1'b0;
        #1;
        total++; if (obs !== O_NORM) begin bad++; $display("FAIL reset_release got=%b want=%b", obs, O_NORM); end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        #1;
        total++; if (obs !== O_STALL) begin bad++; $display("FAIL load_use_c1 got=%b want=%b", obs, O_STALL); end
        total++; if (stall_cnt !== 3'd0) begin bad++; $display("FAIL load_use_cnt got=%0d want=0", stall_cnt); end
        tick();
        clear_ex();
        #1;
        total++; if (obs !== O_NORM) begin bad++; $display("FAIL load_use_c2 got=%b want=%b", obs, O_NORM); end
        total++; if (stall_cnt !== 3'd0) begin bad++; $display("FAIL load_use_cnt2 got=%0d want=0", stall_cnt); end
        tick();
    endtask

    task automatic test_load_branch();
        clear_inputs();
        id_branch = 1'b1; id_uses_rt = 1'b1; id_rs = 5'd3; id_rt = 5'd9;
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd9; branch_taken = 1'b1;
        #1;
        total++; if (obs !== O_STALL) begin bad++; $display("FAIL ld_br_c1 got=%b want=%b", obs, O_STALL); end
        tick();
        clear_ex();
        #1;
        total++; if (obs !== O_STALL) begin bad++; $display("FAIL ld_br_c2 got=%b want=%b", obs, O_STALL); end
        total++; if (stall_cnt !== 3'd1) begin bad++; $display("FAIL ld_br_cnt got=%0d want=1", stall_cnt); end
        tick();
        #1;
        total++; if (obs !== O_FLUSH) begin bad++; $display("FAIL ld_br_flush got=%b want=%b", obs, O_FLUSH); end
        total++; if (stall_cnt !== 3'd0) begin bad++; $display("FAIL ld_br_cnt3 got=%0d want=0", stall_cnt); end
        tick();
    endtask

    task automatic test_alu_branch();
        clear_inputs();
        id_branch = 1'b1; id_rs = 5'd4; ex_regwrite = 1'b1; ex_rd = 5'd4;
        #1;
        total++; if (obs !== O_STALL) begin bad++; $display("FAIL alu_br_c1 got=%b want=%b", obs, O_STALL); end
        tick();
        clear_ex();
        #1;
        total++; if (obs !== O_NORM) begin bad++; $display("FAIL alu_br_c2 got=%b want=%b", obs, O_NORM); end
        tick();
    endtask

    task automatic test_mem_load_branch();
        clear_inputs();
        id_branch = 1'b1; id_rs = 5'd6; mem_memread = 1'b1; mem_access = 1'b1; mem_rd = 5'd6;
        #1;
        total++; if (obs !== O_STALL) begin bad++; $display("FAIL mem_br_c1 got=%b want=%b", obs, O_STALL); end
        tick();
        mem_memread = 1'b0; mem_access = 1'b0; mem_rd = 5'd0;
        #1;
        total++; if (obs !== O_NORM) begin bad++; $display("FAIL mem_br_c2 got=%b want=%b", obs, O_NORM); end
        tick();
    endtask

    task automatic test_reg_zero_rt_gating();
        clear_inputs();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        #1;
        total++; if (obs !== O_NORM) begin bad++; $display("FAIL reg_zero got=%b want=%b", obs, O_NORM); end
        ex_rd = 5'd5; id_rs = 5'd2; id_rt = 5'd5; id_uses_rt = 1'b0;
        #1;
        total++; if (obs !== O_NORM) begin bad++; $display("FAIL rt_gated got=%b want=%b", obs, O_NORM); end
        id_uses_rt = 1'b1;
        #1;
        total++; if (obs !== O_STALL) begin bad++; $display("FAIL rt_used got=%b want=%b", obs, O_STALL); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_mem_wait_in_stall();
        clear_inputs();
        id_branch = 1'b1; id_uses_rt = 1'b1; id_rt = 5'd9;
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd9;
        #1;
        total++; if (obs !== O_STALL) begin bad++; $display("FAIL mw_stall1 got=%b want=%b", obs, O_STALL); end
        tick();
        clear_ex();
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (obs !== O_WAIT) begin bad++; $display("FAIL mw_wait%0d got=%b want=%b", i, obs, O_WAIT); end
            total++; if (stall_cnt !== 3'd1) begin bad++; $display("FAIL mw_cnt%0d got=%0d want=1", i, stall_cnt); end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        total++; if (obs !== O_STALL) begin bad++; $display("FAIL mw_resume got=%b want=%b", obs, O_STALL); end
        total++; if (stall_cnt !== 3'd1) begin bad++; $display("FAIL mw_resume_cnt got=%0d want=1", stall_cnt); end
        tick();
        mem_access = 1'b0;
        #1;
        total++; if (obs !== O_NORM) begin bad++; $display("FAIL mw_normal got=%b want=%b", obs, O_NORM); end
        total++; if (stall_cnt !== 3'd0) begin bad++; $display("FAIL mw_normal_cnt got=%0d want=0", stall_cnt); end
        tick();
    endtask

    task automatic test_idle_mem_wait();
        clear_inputs();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd12; id_rs = 5'd12;
        mem_access = 1'b1; dmem_ready = 1'b0;
        #1;
        total++; if (obs !== O_WAIT) begin bad++; $display("FAIL iw_c1 got=%b want=%b", obs, O_WAIT); end
        tick();
        #1;
        total++; if (obs !== O_WAIT) begin bad++; $display("FAIL iw_c2 got=%b want=%b", obs, O_WAIT); end
        tick();
        dmem_ready = 1'b1;
        #1;
        total++; if (obs !== O_STALL) begin bad++; $display("FAIL iw_ready got=%b want=%b", obs, O_STALL); end
        tick();
        clear_inputs();
        #1;
        total++; if (obs !== O_NORM) begin bad++; $display("FAIL iw_normal got=%b want=%b", obs, O_NORM); end
        tick();
    endtask

    task automatic test_taken_branch();
        clear_inputs();
        id_branch = 1'b1; branch_taken = 1'b1; id_rs = 5'd10;
        ex_regwrite = 1'b1; ex_rd = 5'd11;
        #1;
        total++; if (obs !== O_FLUSH) begin bad++; $display("FAIL taken_flush got=%b want=%b", obs, O_FLUSH); end
        tick();
        branch_taken = 1'b0;
        #1;
        total++; if (obs !== O_NORM) begin bad++; $display("FAIL taken_after got=%b want=%b", obs, O_NORM); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        id_branch = 1'b1; id_rs = 5'd9; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd9;
        #1;
        total++; if (obs !== O_STALL) begin bad++; $display("FAIL rmid_c1 got=%b want=%b", obs, O_STALL); end
        tick();
        clear_ex();
        #1;
        total++; if (stall_cnt !== 3'd1) begin bad++; $display("FAIL rmid_cnt_pre got=%0d want=1", stall_cnt); end
        rst = 1'b1;
        #1;
        total++; if (obs !== O_RST) begin bad++; $display("FAIL rmid_out got=%b want=%b", obs, O_RST); end
        total++; if (stall_cnt !== 3'd0) begin bad++; $display("FAIL rmid_cnt got=%0d want=0", stall_cnt); end
        tick();
        rst = 1'b0;
        clear_inputs();
        id_rs = 5'd7;
        #1;
        total++; if (obs !== O_NORM) begin bad++; $display("FAIL rmid_release got=%b want=%b", obs, O_NORM); end
        tick();
        #1;
        total++; if (obs !== O_NORM) begin bad++; $display("FAIL rmid_next got=%b want=%b", obs, O_NORM); end
        total++; if (stall_cnt !== 3'd0) begin bad++; $display("FAIL rmid_cnt2 got=%0d want=0", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_branch();
        test_mem_load_branch();
        test_reg_zero_rt_gating();
        test_mem_wait_in_stall();
        test_idle_mem_wait();
        test_taken_branch();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised, stateful successor to the pipeline's combinational load-use stall detector.
- Sits beside the IF/ID and ID/EX registers. Decides per cycle whether to:
  - advance normally;
  - stall for a configurable number of cycles (load-use, ALU→branch, load→branch in ID);
  - freeze the whole pipeline while a multi-cycle data memory is busy;
  - flush IF/ID on a taken branch.
- Drives PC write enable, IF/ID write and flush, ID/EX bubble mux select, and EX/MEM hold.

Parameters:
- REG_W, 5: register-specifier width.
- LOAD_USE_STALL, 1: stall cycles when a non-branch ID instruction depends on a load in EX (1..7).
- LOAD_BRANCH_STALL, 2: stall cycles when a branch in ID depends on a load in EX (1..7).
- ALU_BRANCH_STALL, 1: stall cycles when a branch in ID depends on an ALU result in EX (1..7).
- CNT_W, 3: stall counter width; must hold the largest stall parameter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_rs  in  REG_W  rs of instruction in IF/ID
- id_rt  in  REG_W  rt of instruction in IF/ID
- id_uses_rt  in  1  ID instruction reads rt (0 for I-type ALU/loads)
- id_branch  in  1  ID instruction is a branch resolved in ID
- branch_taken  in  1  ID branch comparator result
- ex_regwrite  in  1  EX instruction writes a register
- ex_memread  in  1  EX instruction is a load
- ex_rd  in  REG_W  EX destination register (after RegDst mux)
- mem_memread  in  1  MEM instruction is a load
- mem_access  in  1  MEM instruction is a load or store
- mem_rd  in  REG_W  MEM destination register
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  zero IF/ID on the next edge
- idex_bubble  out  1  select zero control lines into ID/EX
- exmem_hold  out  1  hold EX/MEM and ID/EX contents (memory wait)
- stall_cnt  out  CNT_W  remaining stall cycles, for debug/verification

Behaviour:
- Register matching:
  - match(r) = (r != 0) && (r == id_rs || (id_uses_rt && r == id_rt)).
  - Register 0 never causes a hazard.
- Hazard detection (evaluated only in IDLE), first hit wins:
  - (a) mem_access && !dmem_ready → enter MEM_WAIT;
  - (b) id_branch && ex_memread && match(ex_rd) → N = LOAD_BRANCH_STALL;
  - (c) id_branch && ex_regwrite && !ex_memread && match(ex_rd) → N = ALU_BRANCH_STALL;
  - (d) id_branch && mem_memread && match(mem_rd) → N = 1;
  - (e) !id_branch && ex_memread && match(ex_rd) → N = LOAD_USE_STALL.
- States:
  - IDLE:
    - On (b)–(e): the current cycle is stall cycle 1.
    - If N > 1, load stall_cnt = N−1 and go to STALL; otherwise stay in IDLE.
    - No hazard: all enables high; ifid_flush = id_branch && branch_taken.
  - STALL:
    - Stall outputs held; no re-evaluation of (b)–(e).
    - stall_cnt decrements each cycle; when stall_cnt == 1 and decrementing, next state is IDLE.
  - MEM_WAIT:
    - Entered from IDLE or STALL whenever mem_access && !dmem_ready.
    - stall_cnt is frozen; the return state (IDLE if stall_cnt == 0, else STALL) is used on the cycle dmem_ready rises.
    - The cycle with dmem_ready = 1 is itself non-waiting: it takes the outputs of the return state.
- Outputs by state:
  - Stall cycle (IDLE with hazard, or STALL): pc_write = 0, ifid_write = 0, idex_bubble = 1, exmem_hold = 0, ifid_flush = 0.
  - MEM_WAIT: pc_write = 0, ifid_write = 0, idex_bubble = 0, exmem_hold = 1, ifid_flush = 0.
  - Normal: pc_write = 1, ifid_write = 1, idex_bubble = 0, exmem_hold = 0.
- Flush rules:
  - A taken branch is acted on only in a non-stall, non-wait cycle.
  - branch_taken during a stall or memory wait is ignored, because operands are not yet valid.
- Reset:
  - While rst is high: state = IDLE, stall_cnt = 0, pc_write = 0, ifid_write = 0, ifid_flush = 0, idex_bubble = 0, exmem_hold = 0.
  - Reset asserted mid-STALL or mid-MEM_WAIT discards all pending state immediately.
  - First cycle after release: normal IDLE evaluation.
- Latency: detection-to-output is combinational within the same cycle; only the state and stall_cnt are registered.

Test Plan:
- Load-use: ex_memread = 1, ex_rd = 8, ID add rs = 8 (id_branch = 0), LOAD_USE_STALL = 1 → exactly 1 cycle with pc_write = 0 and idex_bubble = 1, then normal; stall_cnt stays 0.
- Load→branch: ex_memread = 1, ex_rd = 9, ID beq rt = 9 (id_uses_rt = 1) → 2 stall cycles; stall_cnt shows 1 in cycle 2; branch_taken = 1 during the stall does not flush, and flushes on the first normal cycle.
- Register zero and rt gating: ex_memread = 1 with ex_rd = 0 → no stall. ex_rd = 5 = id_rt with id_uses_rt = 0 → no stall.
- Memory wait inside a stall: during the first stall cycle of a load→branch stall, mem_access = 1 and dmem_ready = 0 for 3 cycles → the 3 cycles show exmem_hold = 1, idex_bubble = 0, stall_cnt frozen at 1; then exactly 1 further stall cycle and normal operation.
- Taken branch, no hazard: id_branch = 1, branch_taken = 1, no matches → ifid_flush = 1 for one cycle, pc_write = 1.
- Reset mid-operation: assert rst in cycle 1 of a 2-cycle STALL → outputs immediately reset to the reset values above, stall_cnt = 0; after release, a clean ID instruction proceeds with pc_write = 1 the next cycle.
